// File: rtl/riffa_vector_bridge.sv
// RIFFA channel bridge: RX header + operand vector -> compute core start/done -> TX status + result vector.
// States: IDLE wait request | ACK accept | RX collect beats | COMPUTE run core | TX return beats.
module riffa_vector_bridge #(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int VECTOR_SIZE      = 256,
    parameter int ITER_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                        down_clk,
    input  logic                        RST,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic                        core_start,
    output logic [ITER_WIDTH-1:0]       core_iter,
    output logic [VECTOR_SIZE-1:0]      core_data_in,
    input  logic [VECTOR_SIZE-1:0]      core_data_out,
    input  logic                        core_done,
    output logic                        busy,
    output logic                        err_len,
    output logic                        err_timeout
);
    localparam int W       = C_PCI_DATA_WIDTH;
    localparam int WPB     = W / 32;
    localparam int NB      = VECTOR_SIZE / W;
    localparam int EXP_LEN = (1 + NB) * WPB;
    localparam int SH      = $clog2(WPB);
    localparam int IW      = $clog2(NB + 1);

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_RX, S_COMPUTE, S_TX} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            len_q, len_d, cnt_q, cnt_d, to_cnt_q, to_cnt_d;
    logic [30:0]            off_q, off_d;
    logic [ITER_WIDTH-1:0]  iter_q, iter_d;
    logic [VECTOR_SIZE-1:0] vec_q, vec_d, res_q, res_d;
    logic                   err_len_q, err_len_d, err_to_q, err_to_d;
    logic [IW-1:0]          tx_idx_q, tx_idx_d;

    logic [31:0]            rx_beat;
    logic [32:0]            cnt_sum;
    logic                   rx_done, timeout_hit, tx_last;
    logic [ITER_WIDTH-1:0]  hdr_iter;
    logic [W-1:0]           tx_beat;
    logic                   unused_ok;

    assign unused_ok   = &{1'b0, CHNL_RX_LAST, CHNL_TX_ACK};
    assign CHNL_RX_CLK = down_clk;
    assign CHNL_TX_CLK = down_clk;
    assign CHNL_TX_LAST = 1'b1;

    assign rx_beat     = cnt_q >> SH;
    assign cnt_sum     = {1'b0, cnt_q} + 33'(WPB);
    // A zero length leaves RX immediately without consuming anything.
    assign rx_done     = (len_q == 32'd0) ||
                         (CHNL_RX_DATA_VALID && (cnt_sum >= {1'b0, len_q}));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign tx_last     = (tx_idx_q == IW'(NB));
    assign hdr_iter    = CHNL_RX_DATA[ITER_WIDTH-1:0];

    always_ff @(posedge down_clk or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (CHNL_RX) state_d = S_ACK;
            S_ACK:     state_d = S_RX;
            S_RX:      if (rx_done) state_d = err_len_q ? S_TX : S_COMPUTE;
            S_COMPUTE: if (core_done || timeout_hit) state_d = S_TX;
            S_TX:      if (CHNL_TX_DATA_REN && tx_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d     = len_q;
        off_d     = off_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        iter_d    = iter_q;
        vec_d     = vec_q;
        res_d     = res_q;
        err_len_d = err_len_q;
        err_to_d  = err_to_q;
        tx_idx_d  = tx_idx_q;
        case (state_q)
            S_IDLE: if (CHNL_RX) begin
                len_d     = CHNL_RX_LEN;
                off_d     = CHNL_RX_OFF;
                err_len_d = (CHNL_RX_LEN != 32'(EXP_LEN));
                err_to_d  = 1'b0;
                cnt_d     = '0;
                vec_d     = '0;
                res_d     = '0;
                tx_idx_d  = '0;
            end
            S_RX: begin
                to_cnt_d = '0;
                if (len_q != 32'd0 && CHNL_RX_DATA_VALID) begin
                    cnt_d = cnt_q + 32'(WPB);
                    if (rx_beat == 32'd0)
                        iter_d = (hdr_iter == '0) ? ITER_WIDTH'(1) : hdr_iter;
                    // Data beats land by index so a short transfer leaves the low beats zero.
                    for (int b = 0; b < NB; b++)
                        if (rx_beat == 32'(b + 1))
                            vec_d[VECTOR_SIZE-1-b*W -: W] = CHNL_RX_DATA;
                end
            end
            S_COMPUTE: begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (core_done) begin
                    res_d = core_data_out;
                end else if (timeout_hit) begin
                    err_to_d = 1'b1;
                    res_d    = '0;
                end
            end
            S_TX: if (CHNL_TX_DATA_REN) tx_idx_d = tx_last ? '0 : tx_idx_q + IW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge down_clk or posedge RST) begin
        if (RST) begin
            len_q     <= '0;
            off_q     <= '0;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            iter_q    <= ITER_WIDTH'(1);
            vec_q     <= '0;
            res_q     <= '0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            tx_idx_q  <= '0;
        end else begin
            len_q     <= len_d;
            off_q     <= off_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            iter_q    <= iter_d;
            vec_q     <= vec_d;
            res_q     <= res_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            tx_idx_q  <= tx_idx_d;
        end
    end

    always_comb begin
        tx_beat = '0;
        if (tx_idx_q == '0) begin
            tx_beat[0]               = err_len_q;
            tx_beat[1]               = err_to_q;
            tx_beat[16 +: ITER_WIDTH] = iter_q;
        end
        for (int b = 0; b < NB; b++)
            if (tx_idx_q == IW'(b + 1))
                tx_beat = res_q[VECTOR_SIZE-1-b*W -: W];
    end

    always_comb begin
        CHNL_RX_ACK        = (state_q == S_ACK);
        CHNL_RX_DATA_REN   = (state_q == S_RX);
        CHNL_TX            = (state_q == S_TX);
        CHNL_TX_DATA_VALID = (state_q == S_TX);
        CHNL_TX_LEN        = (state_q == S_TX) ? 32'(EXP_LEN) : 32'd0;
        CHNL_TX_OFF        = (state_q == S_TX) ? off_q : 31'd0;
        CHNL_TX_DATA       = (state_q == S_TX) ? tx_beat : '0;
        core_start         = (state_q == S_COMPUTE) && (to_cnt_q == 32'd0);
        busy               = (state_q != S_IDLE);
    end

    assign core_iter    = iter_q;
    assign core_data_in = vec_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_to_q;
endmodule

// File: tb/tb_riffa_vector_bridge.sv
// Scoreboard bench for riffa_vector_bridge: expected TX beats queued at issue, popped by a TX monitor.
module tb_riffa_vector_bridge;
    logic         down_clk = 1'b0;
    logic         RST = 1'b1;
    logic         CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN;
    logic         CHNL_RX = 1'b0, CHNL_RX_LAST = 1'b0, CHNL_RX_DATA_VALID = 1'b0;
    logic [31:0]  CHNL_RX_LEN = '0;
    logic [30:0]  CHNL_RX_OFF = '0;
    logic [63:0]  CHNL_RX_DATA = '0;
    logic         CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID;
    logic         CHNL_TX_ACK = 1'b0, CHNL_TX_DATA_REN = 1'b0;
    logic [31:0]  CHNL_TX_LEN;
    logic [30:0]  CHNL_TX_OFF;
    logic [63:0]  CHNL_TX_DATA;
    logic         core_start, busy, err_len, err_timeout;
    logic [15:0]  core_iter;
    logic [255:0] core_data_in;
    logic [255:0] core_data_out = '0;
    logic         core_done = 1'b0;

    riffa_vector_bridge #(.C_PCI_DATA_WIDTH(64), .VECTOR_SIZE(256), .ITER_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .down_clk(down_clk), .RST(RST), .CHNL_RX_CLK(CHNL_RX_CLK), .CHNL_RX(CHNL_RX),
        .CHNL_RX_ACK(CHNL_RX_ACK), .CHNL_RX_LAST(CHNL_RX_LAST), .CHNL_RX_LEN(CHNL_RX_LEN),
        .CHNL_RX_OFF(CHNL_RX_OFF), .CHNL_RX_DATA(CHNL_RX_DATA), .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID),
        .CHNL_RX_DATA_REN(CHNL_RX_DATA_REN), .CHNL_TX_CLK(CHNL_TX_CLK), .CHNL_TX(CHNL_TX),
        .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST), .CHNL_TX_LEN(CHNL_TX_LEN),
        .CHNL_TX_OFF(CHNL_TX_OFF), .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN), .core_start(core_start), .core_iter(core_iter),
        .core_data_in(core_data_in), .core_data_out(core_data_out), .core_done(core_done),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 down_clk = ~down_clk;

    int           n_tests = 0, n_fail = 0;
    int           ack_cnt = 0, start_cnt = 0, a0 = 0, s0 = 0;
    logic [63:0]  exp_q[$];
    logic [30:0]  exp_off = '0;
    logic [63:0]  rx_beats [0:7];
    logic [63:0]  prev_data = '0;
    bit           have_prev = 0;

    localparam logic [63:0]  A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0]  B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0]  C = 64'h1111_2222_3333_4444;
    localparam logic [63:0]  D = 64'h5555_6666_7777_8888;
    localparam logic [63:0]  E = 64'hEEEE_0000_EEEE_0000;
    localparam logic [63:0]  F = 64'hFFFF_0000_FFFF_0000;
    localparam logic [255:0] R = 256'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002_0BAD_C0DE_0000_0003_FACE_B00C_0000_0004;
    localparam logic [255:0] R2 = 256'h0102_0304_0506_0708_1112_1314_1516_1718_2122_2324_2526_2728_3132_3334_3536_3738;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // TX monitor / scoreboard consumer.
    always @(negedge down_clk) begin
        if (CHNL_RX_ACK) ack_cnt++;
        if (core_start) start_cnt++;
        if (!RST) begin
            if (have_prev && CHNL_TX_DATA_VALID) chk("tx_stall_hold", CHNL_TX_DATA, prev_data);
            have_prev = CHNL_TX_DATA_VALID && !CHNL_TX_DATA_REN;
            prev_data = CHNL_TX_DATA;
            if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_extra_beat: got %h expected none", CHNL_TX_DATA);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("tx_beat", CHNL_TX_DATA, e);
                    chk("tx_len", CHNL_TX_LEN, 10);
                    chk("tx_off", CHNL_TX_OFF, exp_off);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_rx(input logic [31:0] len, input logic [30:0] off);
        int t = 0; bit got = 0;
        @(posedge down_clk); #1;
        CHNL_RX = 1'b1; CHNL_RX_LEN = len; CHNL_RX_OFF = off;
        while (!got && t < 20) begin
            @(negedge down_clk); got = CHNL_RX_ACK;
            @(posedge down_clk); #1; t++;
        end
        CHNL_RX = 1'b0;
        if (!got) chk("rx_ack_seen", 0, 1);
    endtask

    task automatic rx_one(input logic [63:0] d, input bit gap);
        int t = 0; bit done = 0;
        if (gap) begin CHNL_RX_DATA_VALID = 1'b0; @(posedge down_clk); #1; end
        CHNL_RX_DATA = d; CHNL_RX_DATA_VALID = 1'b1;
        while (!done && t < 50) begin
            @(negedge down_clk); done = CHNL_RX_DATA_REN;
            @(posedge down_clk); #1; t++;
        end
        CHNL_RX_DATA_VALID = 1'b0;
        if (!done) chk("rx_beat_taken", 0, 1);
    endtask

    task automatic issue_txn(input logic [31:0] len, input logic [30:0] off, input int nbeats,
                             input bit gaps, input bit respond, input logic [255:0] res,
                             input logic [63:0] status, input logic [255:0] exp_vec,
                             input logic [15:0] exp_iter);
        a0 = ack_cnt; s0 = start_cnt; exp_off = off;
        exp_q.push_back(status);
        for (int i = 0; i < 4; i++) exp_q.push_back(res[255-64*i -: 64]);
        start_rx(len, off);
        for (int i = 0; i < nbeats; i++) rx_one(rx_beats[i], gaps && (i % 2 == 1));
        @(negedge down_clk);
        chk("core_iter", core_iter, exp_iter);
        chk("core_data_in", core_data_in, exp_vec);
        if (respond) begin
            repeat (2) @(posedge down_clk);
            #1; core_data_out = res; core_done = 1'b1;
            @(posedge down_clk); #1; core_done = 1'b0;
        end
    endtask

    task automatic finish_txn(input bit toggle, input bit e_len, input bit e_to, input int exp_starts);
        int t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            CHNL_TX_DATA_REN = toggle ? (t % 2 == 0) : 1'b1;
            @(posedge down_clk); #1; t++;
        end
        if (exp_q.size() > 0) chk("tx_drain_bound", exp_q.size(), 0);
        CHNL_TX_DATA_REN = 1'b0;
        @(negedge down_clk);
        chk("tx_dropped_after", CHNL_TX, 0);
        chk("busy_after", busy, 0);
        chk("err_len", err_len, e_len);
        chk("err_timeout", err_timeout, e_to);
        chk("ack_pulses", ack_cnt - a0, 1);
        chk("start_pulses", start_cnt - s0, exp_starts);
    endtask

    initial begin
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_tx", CHNL_TX, 0);
        chk("rst_ack", CHNL_RX_ACK, 0);
        chk("rst_iter", core_iter, 1);
        chk("rst_tx_last", CHNL_TX_LAST, 1);
        chk("rst_vec", core_data_in, 0);
        @(negedge down_clk); RST = 1'b0;

        // nominal transfer
        rx_beats[0] = 64'h0000_00AB_0007_0005; rx_beats[1] = A; rx_beats[2] = B; rx_beats[3] = C; rx_beats[4] = D;
        issue_txn(10, 31'h1234, 5, 0, 1, R, 64'h0000_0000_0005_0000, {A, B, C, D}, 16'd5);
        finish_txn(0, 0, 0, 1);

        // RX gaps and TX REN toggling
        issue_txn(10, 31'h55, 5, 1, 1, R, 64'h0000_0000_0005_0000, {A, B, C, D}, 16'd5);
        finish_txn(1, 0, 0, 1);

        // short transfer
        rx_beats[0] = 64'h9; rx_beats[1] = A; rx_beats[2] = B;
        issue_txn(6, 31'h6, 3, 0, 0, '0, 64'h0000_0000_0009_0001, {A, B, 128'h0}, 16'd9);
        finish_txn(0, 1, 0, 0);

        // long transfer, two surplus beats
        rx_beats[0] = 64'h3; rx_beats[1] = A; rx_beats[2] = B; rx_beats[3] = C;
        rx_beats[4] = D; rx_beats[5] = E; rx_beats[6] = F;
        issue_txn(14, 31'h14, 7, 0, 0, '0, 64'h0000_0000_0003_0001, {A, B, C, D}, 16'd3);
        finish_txn(0, 1, 0, 0);

        // core never finishes
        rx_beats[0] = 64'h7; rx_beats[1] = A; rx_beats[2] = B; rx_beats[3] = C; rx_beats[4] = D;
        issue_txn(10, 31'h77, 5, 0, 0, '0, 64'h0000_0000_0007_0002, {A, B, C, D}, 16'd7);
        finish_txn(0, 0, 1, 1);

        // reset while TX presents beat 2
        rx_beats[0] = 64'h5;
        issue_txn(10, 31'h99, 5, 0, 1, R, 64'h0000_0000_0005_0000, {A, B, C, D}, 16'd5);
        begin
            int t = 0;
            while (exp_q.size() > 3 && t < 100) begin
                CHNL_TX_DATA_REN = 1'b1; @(posedge down_clk); #1; t++;
            end
            CHNL_TX_DATA_REN = 1'b0;
            chk("pre_reset_beats", exp_q.size(), 3);
        end
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_tx", CHNL_TX, 0);
        chk("mid_rst_valid", CHNL_TX_DATA_VALID, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_iter", core_iter, 1);
        chk("mid_rst_vec", core_data_in, 0);
        exp_q.delete();
        @(posedge down_clk); #1; RST = 1'b0;

        // recovery, zero header clamps to one
        rx_beats[0] = 64'hFFFF_0000; rx_beats[1] = D; rx_beats[2] = C; rx_beats[3] = B; rx_beats[4] = A;
        issue_txn(10, 31'h42, 5, 0, 1, R2, 64'h0000_0000_0001_0000, {D, C, B, A}, 16'd1);
        finish_txn(0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riffa_vector_bridge.md
Name: riffa_vector_bridge

Overview:
- Parametrised RIFFA channel bridge between one PCIe channel and a compute core (mult_top-style start/done interface).
- Per RX transaction it captures one header beat (iteration count) and one VECTOR_SIZE operand vector, pulses the core, and waits for completion with a timeout.
- It then returns a status beat plus the result vector on the TX channel.
- Adds length checking, error status, a configurable datapath width and a core timeout.

Parameters:
- C_PCI_DATA_WIDTH, 64, RIFFA beat width; must be 32, 64 or 128.
- VECTOR_SIZE, 256, operand/result vector width; must be an integer multiple of C_PCI_DATA_WIDTH.
- ITER_WIDTH, 16, width of the iteration count passed to the core.
- TIMEOUT_CYCLES, 65535, maximum down_clk cycles to wait for core_done; 0 disables the timeout.

Ports:
- down_clk  in  1  sole clock; also drives CHNL_RX_CLK and CHNL_TX_CLK.
- RST  in  1  asynchronous, active-high reset.
- CHNL_RX_CLK  out  1  equals down_clk.
- CHNL_RX  in  1  host RX transaction request.
- CHNL_RX_ACK  out  1  RX accept.
- CHNL_RX_LAST  in  1  ignored.
- CHNL_RX_LEN  in  32  RX length in 32-bit words.
- CHNL_RX_OFF  in  31  RX offset; latched.
- CHNL_RX_DATA  in  C_PCI_DATA_WIDTH  RX beat.
- CHNL_RX_DATA_VALID  in  1  RX beat valid.
- CHNL_RX_DATA_REN  out  1  RX beat read-enable.
- CHNL_TX_CLK  out  1  equals down_clk.
- CHNL_TX  out  1  TX transaction request.
- CHNL_TX_ACK  in  1  ignored.
- CHNL_TX_LAST  out  1  constant 1.
- CHNL_TX_LEN  out  32  TX length in words.
- CHNL_TX_OFF  out  31  TX offset.
- CHNL_TX_DATA  out  C_PCI_DATA_WIDTH  TX beat.
- CHNL_TX_DATA_VALID  out  1  TX beat valid.
- CHNL_TX_DATA_REN  in  1  host accepts TX beat.
- core_start  out  1  one-cycle start pulse to the core.
- core_iter  out  ITER_WIDTH  iteration count to the core.
- core_data_in  out  VECTOR_SIZE  operand vector; stable from core_start until the next RX accept.
- core_data_out  in  VECTOR_SIZE  result vector; sampled on core_done.
- core_done  in  1  core completion.
- busy  out  1  high whenever state is not IDLE.
- err_len  out  1  length error for the current transaction.
- err_timeout  out  1  core timeout for the current transaction.

Behaviour:
- Derived constants:
  - WPB = C_PCI_DATA_WIDTH/32 (words per beat).
  - NB = VECTOR_SIZE/C_PCI_DATA_WIDTH (data beats per vector).
  - EXP_LEN = (1+NB)*WPB.
- Reset, asserted asynchronously at any time including mid-transaction:
  - state goes to IDLE.
  - All outputs 0 except core_iter=1 and CHNL_TX_LAST=1.
  - Vector, result and counter registers 0.
- States: IDLE, ACK, RX, COMPUTE, TX.
- IDLE:
  - When CHNL_RX=1: latch len and off, clear err_len, err_timeout, the word count and the vector register; go to ACK.
  - If the latched len != EXP_LEN, set err_len in the same cycle.
- ACK: CHNL_RX_ACK=1 for exactly one cycle, then go to RX.
- RX:
  - CHNL_RX_DATA_REN=1 throughout.
  - Each cycle with VALID=1 adds WPB to the word count.
  - Beat 0: core_iter <= data[ITER_WIDTH-1:0]; a value of 0 is clamped to 1.
  - Beats 1..NB are shifted in MSB-first; the first data beat ends up in the top bits.
  - Beats after NB are consumed and discarded.
  - Leave RX in the cycle where (count + WPB on a valid beat) >= latched len.
  - len=0: leave RX after one cycle with err_len=1 and no beats consumed.
  - Short transfer: the unreceived low beats of the vector remain 0.
  - Next state: COMPUTE if err_len=0, otherwise TX with a zero result.
- COMPUTE:
  - core_start=1 on the first cycle only.
  - A timeout counter starts at 0 and increments every cycle.
  - core_done=1: latch core_data_out and go to TX. This takes priority over a timeout in the same cycle.
  - Counter reaches TIMEOUT_CYCLES (when nonzero): set err_timeout, result=0, go to TX.
  - core_done outside COMPUTE is ignored.
- TX:
  - CHNL_TX=1 and CHNL_TX_DATA_VALID=1 continuously.
  - CHNL_TX_LEN=EXP_LEN; CHNL_TX_OFF = latched off.
  - Beat 0 is the status beat: bit0=err_len, bit1=err_timeout, bits[16+ITER_WIDTH-1:16]=core_iter, all other bits 0.
  - Beats 1..NB are the result, MSB-first.
  - A beat advances only in a cycle with VALID & REN.
  - After the last beat is accepted, go to IDLE; CHNL_TX and VALID are 0 the next cycle.
  - REN held low stalls indefinitely with data held stable.
- CHNL_RX asserted outside IDLE is not acknowledged. Back-to-back transactions are accepted one cycle after returning to IDLE.
- err_len and err_timeout remain valid until the next RX accept.
- Word counter is 32 bits; wrap is unreachable because len is at most 2^32-1.

Test Plan:
- W=64, VS=256, len=10, header=5, data beats A,B,C,D (VALID every cycle):
  - ACK pulses once; core_iter=5; core_data_in={A,B,C,D}; core_start pulses once.
  - Core returns R at done → TX_LEN=10; beats {status=0x0005_0000, R[255:192], …, R[63:0]}; then IDLE.
- Same transfer with REN toggling 1,0,1,0 and VALID gaps on RX → identical data; no beat is duplicated or dropped.
- len=6 (short) → err_len=1; no core_start; TX returns status bit0=1 followed by 4 zero beats.
- len=14 (long) → extra 2 beats consumed; err_len=1; TX sends status plus zero result.
- TIMEOUT_CYCLES=8 with core_done never asserted → after 8 cycles err_timeout=1; status bit1=1; zero result.
- RST asserted during TX beat 2 → CHNL_TX=0 immediately, outputs at reset values; a following 10-word transfer completes normally.
